usb_rx_sequencer: RTL

Receive-path controller for the low-speed (1.5 Mbps) USB transceiver, clocked at 48 MHz (32 clocks per bit).
- Consumes one NRZI-decoded bit per bit_strobe from the clock-recovery/NRZI stage, plus the level rx_eop from the EOP detector.
- Sequences the packet: SYNC hunt, bit unstuffing, LSB-first byte assembly, end-of-packet check and error reporting.
- Presents a byte stream to the packet/PID layer.

---
 rtl/usb_rx_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/usb_rx_sequencer.sv
// Low-speed USB receive sequencer: SYNC hunt, bit unstuffing, LSB-first byte
// assembly, EOP alignment check, overflow/timeout detection and error reporting.
module usb_rx_sequencer #(
    parameter int unsigned SYNC_MIN_ZEROS = 5,
    parameter int unsigned MAX_BYTES      = 16,
    parameter int unsigned BIT_TIMEOUT    = 160
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_strobe,
    input  logic       bit_data,
    input  logic       rx_eop,
    output logic       rx_active,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_error,
    output logic [2:0] rx_err_code
);

    localparam int unsigned BYTE_W = $clog2(MAX_BYTES + 1);
    localparam int unsigned IDLE_W = $clog2(BIT_TIMEOUT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_DATA, ST_DRAIN} state_t;

    state_t             state, state_nxt;
    logic [2:0]         zero_cnt, zero_nxt;
    logic [2:0]         ones_cnt, ones_nxt;
    logic [2:0]         bit_cnt, bit_nxt;
    logic [BYTE_W-1:0]  byte_cnt, byte_nxt;
    logic [IDLE_W-1:0]  idle_cnt, idle_nxt;
    logic [7:0]         shift, shift_nxt;
    logic               rx_eop_q;
    logic               eop_rise;
    logic               active_nxt, valid_nxt, error_nxt;
    logic [7:0]         data_nxt;
    logic [2:0]         code_nxt;

    assign eop_rise = rx_eop & ~rx_eop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            zero_cnt    <= '0;
            ones_cnt    <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            idle_cnt    <= '0;
            shift       <= '0;
            rx_eop_q    <= 1'b0;
            rx_active   <= 1'b0;
            rx_valid    <= 1'b0;
            rx_data     <= '0;
            rx_error    <= 1'b0;
            rx_err_code <= '0;
        end else begin
            state       <= state_nxt;
            zero_cnt    <= zero_nxt;
            ones_cnt    <= ones_nxt;
            bit_cnt     <= bit_nxt;
            byte_cnt    <= byte_nxt;
            idle_cnt    <= idle_nxt;
            shift       <= shift_nxt;
            rx_eop_q    <= rx_eop;
            rx_active   <= active_nxt;
            rx_valid    <= valid_nxt;
            rx_data     <= data_nxt;
            rx_error    <= error_nxt;
            rx_err_code <= code_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        zero_nxt   = zero_cnt;
        ones_nxt   = ones_cnt;
        bit_nxt    = bit_cnt;
        byte_nxt   = byte_cnt;
        idle_nxt   = idle_cnt;
        shift_nxt  = shift;
        active_nxt = rx_active;
        valid_nxt  = 1'b0;
        data_nxt   = rx_data;
        error_nxt  = 1'b0;
        code_nxt   = rx_err_code;

        case (state)
            ST_IDLE: begin
                if (bit_strobe) begin
                    if (!bit_data) begin
                        if (zero_cnt != 3'd7) zero_nxt = zero_cnt + 3'd1;
                    end else begin
                        zero_nxt = '0;
                        if (zero_cnt >= 3'(SYNC_MIN_ZEROS)) begin
                            state_nxt  = ST_DATA;
                            active_nxt = 1'b1;
                            ones_nxt   = '0;
                            bit_nxt    = '0;
                            byte_nxt   = '0;
                            idle_nxt   = '0;
                            shift_nxt  = '0;
                        end
                    end
                end
            end

            ST_DATA: begin
                // EOP takes priority over a coincident strobe; that bit is dropped
                if (eop_rise) begin
                    state_nxt  = ST_IDLE;
                    active_nxt = 1'b0;
                    if (bit_cnt != '0) begin
                        error_nxt = 1'b1;
                        code_nxt  = 3'd2;
                    end
                end else if (bit_strobe) begin
                    idle_nxt = '0;
                    if (ones_cnt == 3'd6) begin
                        if (bit_data) begin
                            error_nxt = 1'b1;
                            code_nxt  = 3'd1;
                            state_nxt = ST_DRAIN;
                        end else begin
                            ones_nxt = '0;
                        end
                    end else begin
                        ones_nxt  = bit_data ? ones_cnt + 3'd1 : 3'd0;
                        shift_nxt = {bit_data, shift[7:1]};
                        if (bit_cnt == 3'd7) begin
                            bit_nxt = '0;
                            if (byte_cnt == BYTE_W'(MAX_BYTES)) begin
                                error_nxt = 1'b1;
                                code_nxt  = 3'd3;
                                state_nxt = ST_DRAIN;
                            end else begin
                                valid_nxt = 1'b1;
                                data_nxt  = shift_nxt;
                                byte_nxt  = byte_cnt + 1'b1;
                            end
                        end else begin
                            bit_nxt = bit_cnt + 3'd1;
                        end
                    end
                end else if (idle_cnt == IDLE_W'(BIT_TIMEOUT - 1)) begin
                    error_nxt  = 1'b1;
                    code_nxt   = 3'd4;
                    state_nxt  = ST_IDLE;
                    active_nxt = 1'b0;
                end else begin
                    idle_nxt = idle_cnt + 1'b1;
                end
            end

            ST_DRAIN: begin
                if (eop_rise) begin
                    state_nxt  = ST_IDLE;
                    active_nxt = 1'b0;
                end else if (bit_strobe) begin
                    idle_nxt = '0;
                end else if (idle_cnt == IDLE_W'(BIT_TIMEOUT - 1)) begin
                    error_nxt  = 1'b1;
                    code_nxt   = 3'd4;
                    state_nxt  = ST_IDLE;
                    active_nxt = 1'b0;
                end else begin
                    idle_nxt = idle_cnt + 1'b1;
                end
            end

            default: begin
                state_nxt  = ST_IDLE;
                active_nxt = 1'b0;
            end
        endcase
    end

endmodule
